// File: rtl/core_pkg.sv
// Shared constants and types for the 24-bit, 16-register core.
package core_pkg;
  localparam int DATA_W = 24;
  localparam int REG_AW = 4;

  // Write-back stage load tracking: IDLE = nothing outstanding, WAIT = load pending
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;
endpackage

// File: rtl/load_wait_timer.sv
// Cycle counter for an outstanding load: start loads 1, clear zeroes,
// otherwise counts up and saturates at TIMEOUT.
module load_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  output logic             expired,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: start wins over clear, then saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (start)              cnt_d = CNT_W'(1);
    else if (clear)         cnt_d = '0;
    else if (cnt_q != TMAX) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count   = cnt_q;
  assign expired = (cnt_q == TMAX);
endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register. Selects ALU or load data for write-back and
// holds upstream via Stall while a variable-latency load is outstanding.
// A load that outlives TIMEOUT cycles is dropped and flagged in LoadTimeout.
module mem_wb_stage #(
  parameter int DATA_W  = core_pkg::DATA_W,
  parameter int REG_AW  = core_pkg::REG_AW,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              InValid,
  input  logic              MemRead,
  input  logic              InRegWrite,
  input  logic [REG_AW-1:0] InWriteRegister,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              DmemRValid,
  input  logic [DATA_W-1:0] DmemRData,
  input  logic              Flush,
  output logic              Stall,
  output logic [REG_AW-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              LoadTimeout
);
  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMAX  = CNT_W'(TIMEOUT);

  core_pkg::wb_state_t state_q, state_d;
  logic [REG_AW-1:0]   wr_reg_q, wr_reg_d, lat_dest_q, lat_dest_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                reg_write_q, reg_write_d, lat_rw_q, lat_rw_d;
  logic                timeout_q, timeout_d;
  logic                tmr_start, tmr_clear, tmr_expired;
  logic [CNT_W-1:0]    tmr_count;

  logic idle_miss;
  assign idle_miss = (state_q == core_pkg::IDLE) & InValid & MemRead & ~DmemRValid & ~Flush;

  load_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tmr_start),
    .clear   (tmr_clear),
    .expired (tmr_expired),
    .count   (tmr_count)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= core_pkg::IDLE;
    else        state_q <= state_d;
  end

  // Next state and timer control; the timer only runs while in WAIT
  always_comb begin
    state_d   = state_q;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    case (state_q)
      core_pkg::IDLE: begin
        if (idle_miss) begin
          state_d   = core_pkg::WAIT;
          tmr_start = 1'b1;
        end else begin
          tmr_clear = 1'b1;
        end
      end
      core_pkg::WAIT: begin
        if (Flush || DmemRValid || tmr_expired) begin
          state_d   = core_pkg::IDLE;
          tmr_clear = 1'b1;
        end
      end
      default: begin
        state_d   = core_pkg::IDLE;
        tmr_clear = 1'b1;
      end
    endcase
  end

  // Capture / latch / timeout decisions; RegWrite defaults to a bubble
  always_comb begin
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    reg_write_d = 1'b0;
    timeout_d   = timeout_q;
    lat_dest_d  = lat_dest_q;
    lat_rw_d    = lat_rw_q;
    case (state_q)
      core_pkg::IDLE: begin
        if (InValid && !Flush) begin
          if (!MemRead) begin
            wr_data_d   = ALUResult;
            wr_reg_d    = InWriteRegister;
            reg_write_d = InRegWrite;
          end else if (DmemRValid) begin
            wr_data_d   = DmemRData;
            wr_reg_d    = InWriteRegister;
            reg_write_d = InRegWrite;
          end else begin
            lat_dest_d  = InWriteRegister;
            lat_rw_d    = InRegWrite;
          end
        end
      end
      core_pkg::WAIT: begin
        // Flush beats a completing load; the held upstream instruction is ignored
        if (!Flush) begin
          if (DmemRValid) begin
            wr_data_d   = DmemRData;
            wr_reg_d    = lat_dest_q;
            reg_write_d = lat_rw_q;
          end else if (tmr_expired) begin
            timeout_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Write-back registers and latched load fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      reg_write_q <= 1'b0;
      timeout_q   <= 1'b0;
      lat_dest_q  <= '0;
      lat_rw_q    <= 1'b0;
    end else begin
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      reg_write_q <= reg_write_d;
      timeout_q   <= timeout_d;
      lat_dest_q  <= lat_dest_d;
      lat_rw_q    <= lat_rw_d;
    end
  end

  // Stall drops in the cycle the load completes, times out or is flushed
  assign Stall = ((state_q == core_pkg::WAIT) & ~DmemRValid & ~Flush & (tmr_count != TMAX))
               | idle_miss;

  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;
  assign RegWrite      = reg_write_q;
  assign LoadTimeout   = timeout_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed vector bench for mem_wb_stage with TIMEOUT=4.
module tb_mem_wb_stage;
  localparam int DW = 24;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, mem_read, in_rw, dv, flush;
  logic [AW-1:0] in_dest;
  logic [DW-1:0] alu, dd;
  logic          stall, rw, to;
  logic [AW-1:0] wreg;
  logic [DW-1:0] wdata;

  int pass_cnt = 0;
  int total    = 0;

  mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .InValid         (in_valid),
    .MemRead         (mem_read),
    .InRegWrite      (in_rw),
    .InWriteRegister (in_dest),
    .ALUResult       (alu),
    .DmemRValid      (dv),
    .DmemRData       (dd),
    .Flush           (flush),
    .Stall           (stall),
    .WriteRegister   (wreg),
    .WriteData       (wdata),
    .RegWrite        (rw),
    .LoadTimeout     (to)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus: inputs, Stall during the cycle, outputs after the edge
  typedef struct {
    logic          iv, mr, irw, v, fl;
    logic [AW-1:0] dst;
    logic [DW-1:0] a, d;
    logic          e_stall, e_rw, e_to;
    logic [AW-1:0] e_reg;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic iv, logic mr, logic irw, logic [AW-1:0] dst,
                              logic [DW-1:0] a, logic v, logic [DW-1:0] d, logic fl,
                              logic e_stall, logic e_rw, logic [AW-1:0] e_reg,
                              logic [DW-1:0] e_data, logic e_to);
    vec_t r;
    r.iv = iv; r.mr = mr; r.irw = irw; r.dst = dst; r.a = a; r.v = v; r.d = d; r.fl = fl;
    r.e_stall = e_stall; r.e_rw = e_rw; r.e_reg = e_reg; r.e_data = e_data; r.e_to = e_to;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic drive(logic iv, logic mr, logic irw, logic [AW-1:0] dst,
                       logic [DW-1:0] a, logic v, logic [DW-1:0] d, logic fl);
    in_valid = iv; mem_read = mr; in_rw = irw; in_dest = dst;
    alu = a; dv = v; dd = d; flush = fl;
  endtask

  initial begin
    drive(0, 0, 0, '0, '0, 0, '0, 0);
    rst_n = 1'b0;
    #12;
    chk("reset_rw",    -1, 32'(rw),    0);
    chk("reset_reg",   -1, 32'(wreg),  0);
    chk("reset_data",  -1, 32'(wdata), 0);
    chk("reset_to",    -1, 32'(to),    0);
    chk("reset_stall", -1, 32'(stall), 0);
    @(negedge clk);
    rst_n = 1'b1;

    //                 iv mr rw dst  alu        v  dmem       fl | stall rw reg data       to
    vq.push_back(mk(1, 0, 1, 4'd5, 24'h00ABCD, 0, 24'h0,      0,   0,   1, 4'd5, 24'h00ABCD, 0)); // ALU op
    vq.push_back(mk(0, 0, 0, 4'd0, 24'h0,      0, 24'h0,      0,   0,   0, 4'd5, 24'h00ABCD, 0)); // bubble, hold
    vq.push_back(mk(1, 1, 1, 4'd3, 24'h0,      1, 24'h123456, 0,   0,   1, 4'd3, 24'h123456, 0)); // zero-wait load
    vq.push_back(mk(1, 1, 1, 4'd7, 24'h111111, 0, 24'h0,      0,   1,   0, 4'd3, 24'h123456, 0)); // 3-cycle load
    vq.push_back(mk(1, 1, 1, 4'd7, 24'h111111, 0, 24'h0,      0,   1,   0, 4'd3, 24'h123456, 0));
    vq.push_back(mk(1, 1, 1, 4'd7, 24'h111111, 0, 24'h0,      0,   1,   0, 4'd3, 24'h123456, 0));
    vq.push_back(mk(1, 1, 1, 4'd7, 24'h111111, 1, 24'hFFFFFF, 0,   0,   1, 4'd7, 24'hFFFFFF, 0)); // completes
    vq.push_back(mk(0, 0, 0, 4'd0, 24'h0,      0, 24'h0,      0,   0,   0, 4'd7, 24'hFFFFFF, 0)); // no duplicate
    vq.push_back(mk(0, 0, 0, 4'd0, 24'h0,      1, 24'hAAAAAA, 0,   0,   0, 4'd7, 24'hFFFFFF, 0)); // stray valid
    vq.push_back(mk(1, 1, 1, 4'd9, 24'h0,      0, 24'h0,      0,   1,   0, 4'd7, 24'hFFFFFF, 0)); // timeout load
    vq.push_back(mk(1, 1, 1, 4'd9, 24'h0,      0, 24'h0,      0,   1,   0, 4'd7, 24'hFFFFFF, 0));
    vq.push_back(mk(1, 1, 1, 4'd9, 24'h0,      0, 24'h0,      0,   1,   0, 4'd7, 24'hFFFFFF, 0));
    vq.push_back(mk(1, 1, 1, 4'd9, 24'h0,      0, 24'h0,      0,   1,   0, 4'd7, 24'hFFFFFF, 0));
    vq.push_back(mk(1, 1, 1, 4'd9, 24'h0,      0, 24'h0,      0,   0,   0, 4'd7, 24'hFFFFFF, 1)); // dropped
    vq.push_back(mk(1, 0, 1, 4'd2, 24'h000042, 0, 24'h0,      0,   0,   1, 4'd2, 24'h000042, 1)); // ALU after timeout
    vq.push_back(mk(1, 1, 1, 4'hA, 24'h0,      0, 24'h0,      0,   1,   0, 4'd2, 24'h000042, 1)); // load then flush
    vq.push_back(mk(1, 1, 1, 4'hA, 24'h0,      1, 24'h555555, 1,   0,   0, 4'd2, 24'h000042, 1)); // flush beats valid
    vq.push_back(mk(0, 0, 0, 4'd0, 24'h0,      0, 24'h0,      0,   0,   0, 4'd2, 24'h000042, 1));
    vq.push_back(mk(1, 0, 1, 4'd4, 24'h777777, 0, 24'h0,      1,   0,   0, 4'd2, 24'h000042, 1)); // flush in IDLE
    vq.push_back(mk(1, 0, 0, 4'd0, 24'h000099, 0, 24'h0,      0,   0,   0, 4'd0, 24'h000099, 1)); // r0, no RegWrite
    vq.push_back(mk(1, 1, 1, 4'd6, 24'h0,      0, 24'h0,      1,   0,   0, 4'd0, 24'h000099, 1)); // flushed miss
    vq.push_back(mk(1, 0, 1, 4'd1, 24'h000001, 0, 24'h0,      0,   0,   1, 4'd1, 24'h000001, 1)); // still IDLE

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].iv, vq[i].mr, vq[i].irw, vq[i].dst, vq[i].a, vq[i].v, vq[i].d, vq[i].fl);
      #1;
      chk("stall", i, 32'(stall), 32'(vq[i].e_stall));
      @(posedge clk);
      #1;
      chk("regwrite", i, 32'(rw),    32'(vq[i].e_rw));
      chk("wreg",     i, 32'(wreg),  32'(vq[i].e_reg));
      chk("wdata",    i, 32'(wdata), 32'(vq[i].e_data));
      chk("timeout",  i, 32'(to),    32'(vq[i].e_to));
    end

    // Async reset while a load is outstanding
    @(negedge clk);
    drive(1, 1, 1, 4'd6, '0, 0, '0, 0);
    @(posedge clk);
    #2;
    drive(0, 0, 0, '0, '0, 0, '0, 0);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_rw",    100, 32'(rw),    0);
    chk("midwait_rst_reg",   100, 32'(wreg),  0);
    chk("midwait_rst_data",  100, 32'(wdata), 0);
    chk("midwait_rst_to",    100, 32'(to),    0);
    chk("midwait_rst_stall", 100, 32'(stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, '0, '0, 1, 24'hBBBBBB, 0);
    #1;
    chk("stale_stall", 101, 32'(stall), 0);
    @(posedge clk);
    #1;
    chk("stale_rw",   101, 32'(rw),    0);
    chk("stale_data", 101, 32'(wdata), 0);
    chk("stale_reg",  101, 32'(wreg),  0);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, 0, '0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
